exe_stage_mc: RTL and testbench

Parametrised execute stage for the ARM-subset pipeline. Generates the second ALU operand, runs the ALU, and computes the branch target. Adds what the single-cycle stage lacked: an internal status register with S-bit update, a registered EXE/MEM output with valid/flush, and an iterative multi-cycle MUL that stalls the front end. Sits between the ID/EXE register and the MEM stage.

---
 rtl/exe_pkg.sv | 32 +++
 rtl/val2_gen.sv | 54 +++++
 rtl/exe_stage_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_exe_stage_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: ALU command encodings, status
// flag bit positions, shifter type codes and the multiplier FSM states.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  // Bit positions inside the {N,Z,C,V} status register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } exe_state_e;

endpackage

// File: rtl/val2_gen.sv
// Second ALU operand generator. Memory ops use the raw 12-bit offset,
// immediates are an 8-bit value rotated right by twice the 4-bit rotate
// field, and register operands go through the barrel shifter.
import exe_pkg::*;

module val2_gen #(
  parameter int DATA_W = 32
) (
  input  logic              mem_en_i,
  input  logic              imm_i,
  input  logic [11:0]       shift_operand_i,
  input  logic [DATA_W-1:0] val_rm_i,
  output logic [DATA_W-1:0] val2_o
);

  logic [4:0] shAmt;
  logic [1:0] shType;
  logic [4:0] immRot;

  assign shAmt  = shift_operand_i[11:7];
  assign shType = shift_operand_i[6:5];
  assign immRot = {shift_operand_i[11:8], 1'b0};

  // Rotate right; the amount wraps modulo the datapath width so narrow
  // configurations still behave as a true rotate.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input logic [4:0] amt);
    logic [2*DATA_W-1:0] dbl;
    int a;
    a   = int'(amt) % DATA_W;
    dbl = {x, x} >> a;
    return dbl[DATA_W-1:0];
  endfunction

  // Select the operand source, memory offset first, then immediate, then shifter
  always_comb begin
    val2_o = '0;
    if (mem_en_i) begin
      val2_o = {{(DATA_W-12){1'b0}}, shift_operand_i};
    end else if (imm_i) begin
      val2_o = rotr({{(DATA_W-8){1'b0}}, shift_operand_i[7:0]}, immRot);
    end else if (shAmt == 5'd0) begin
      val2_o = val_rm_i;
    end else begin
      case (shType)
        SH_LSL:  val2_o = val_rm_i << shAmt;
        SH_LSR:  val2_o = val_rm_i >> shAmt;
        SH_ASR:  val2_o = $unsigned($signed(val_rm_i) >>> shAmt);
        default: val2_o = rotr(val_rm_i, shAmt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: ALU with status register, branch target adder,
// registered EXE/MEM outputs with valid/flush, and a bit-serial multiplier
// that holds the front end with busy while it iterates.
import exe_pkg::*;

module exe_stage_mc #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              busy,
  input  logic [3:0]        EXE_CMD,
  input  logic              S,
  input  logic              imm,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Val_Rn,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [11:0]       Shift_operand,
  input  logic [IMM_W-1:0]  Signed_imm_24,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Br_addr,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [3:0]        SR
);

  localparam int EXT_W = (DATA_W > IMM_W) ? DATA_W : IMM_W;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam int MSB = DATA_W - 1;

  exe_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mulA_q, mulA_d;
  logic [DATA_W-1:0] mulB_q, mulB_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              mulS_q, mulS_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] br_q, br_d;
  logic              memR_q, memR_d;
  logic              memW_q, memW_d;
  logic [3:0]        SR_q, SR_d;

  logic              memOp;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] addB;
  logic              addCin;
  logic [DATA_W:0]   sum;
  logic              vFlag;
  logic              nzUpd;
  logic              cvUpd;
  logic              isMul;
  logic [DATA_W-1:0] aluRes;
  logic [3:0]        aluFlags;
  logic [DATA_W-1:0] mulStep;
  logic              accept;

  logic signed [EXT_W-1:0] brOffExt;
  logic [EXT_W-1:0]        brOffShift;
  logic [DATA_W-1:0]       brAddr;

  assign memOp = MEM_R_EN | MEM_W_EN;

  val2_gen #(.DATA_W(DATA_W)) u_val2 (
    .mem_en_i        (memOp),
    .imm_i           (imm),
    .shift_operand_i (Shift_operand),
    .val_rm_i        (Val_Rm),
    .val2_o          (val2)
  );

  // Word offset sign-extended then scaled to bytes; the add wraps naturally
  assign brOffExt   = EXT_W'($signed(Signed_imm_24));
  assign brOffShift = brOffExt << 2;
  assign brAddr     = PC + brOffShift[DATA_W-1:0];

  // One shared adder serves ADD/ADC/SUB/SBC; subtraction is a + ~b + cin,
  // so overflow is the same sign test against the effective addend.
  always_comb begin
    addB   = val2;
    addCin = 1'b0;
    case (EXE_CMD)
      CMD_ADC: addCin = SR_q[FLAG_C];
      CMD_SUB: begin addB = ~val2; addCin = 1'b1; end
      CMD_SBC: begin addB = ~val2; addCin = SR_q[FLAG_C]; end
      default: ;
    endcase
    sum   = {1'b0, Val_Rn} + {1'b0, addB} + {{DATA_W{1'b0}}, addCin};
    vFlag = (Val_Rn[MSB] == addB[MSB]) && (sum[MSB] != Val_Rn[MSB]);
  end

  // ALU result and candidate flags; memory ops compute an address and
  // never touch the flags, unknown commands give zero with flags held.
  always_comb begin
    aluRes   = '0;
    aluFlags = SR_q;
    nzUpd    = 1'b0;
    cvUpd    = 1'b0;
    isMul    = 1'b0;
    if (memOp) begin
      aluRes = Val_Rn + val2;
    end else begin
      case (EXE_CMD)
        CMD_MOV: begin aluRes = val2;          nzUpd = 1'b1; end
        CMD_MVN: begin aluRes = ~val2;         nzUpd = 1'b1; end
        CMD_AND: begin aluRes = Val_Rn & val2; nzUpd = 1'b1; end
        CMD_ORR: begin aluRes = Val_Rn | val2; nzUpd = 1'b1; end
        CMD_EOR: begin aluRes = Val_Rn ^ val2; nzUpd = 1'b1; end
        CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
          aluRes = sum[DATA_W-1:0];
          nzUpd  = 1'b1;
          cvUpd  = 1'b1;
        end
        CMD_MUL: isMul = (MUL_EN != 0);
        default: ;
      endcase
    end
    if (nzUpd) begin
      aluFlags[FLAG_N] = aluRes[MSB];
      aluFlags[FLAG_Z] = (aluRes == '0);
    end
    if (cvUpd) begin
      aluFlags[FLAG_C] = sum[DATA_W];
      aluFlags[FLAG_V] = vFlag;
    end
  end

  assign accept  = (state_q == ST_IDLE) && in_valid && !flush;
  assign mulStep = acc_q + (mulB_q[0] ? mulA_q : '0);

  // Next-state logic: IDLE registers single-cycle results or launches a
  // multiply; MUL_RUN adds one partial product per cycle until the last bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mulA_d     = mulA_q;
    mulB_d     = mulB_q;
    acc_d      = acc_q;
    mulS_d     = mulS_q;
    outValid_d = 1'b0;
    result_d   = result_q;
    br_d       = br_q;
    memR_d     = 1'b0;
    memW_d     = 1'b0;
    SR_d       = SR_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          br_d = brAddr;
          if (isMul) begin
            state_d = ST_MUL_RUN;
            mulA_d  = Val_Rn;
            mulB_d  = Val_Rm;
            acc_d   = '0;
            cnt_d   = '0;
            mulS_d  = S;
          end else begin
            outValid_d = 1'b1;
            result_d   = aluRes;
            memR_d     = MEM_R_EN;
            memW_d     = MEM_W_EN;
            if (S && (nzUpd || cvUpd)) SR_d = aluFlags;
          end
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = mulStep;
          mulA_d = mulA_q << 1;
          mulB_d = mulB_q >> 1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d    = ST_IDLE;
            outValid_d = 1'b1;
            result_d   = mulStep;
            if (mulS_q) begin
              SR_d[FLAG_N] = mulStep[MSB];
              SR_d[FLAG_Z] = (mulStep == '0);
            end
          end
        end
      end
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      acc_q      <= '0;
      mulS_q     <= 1'b0;
      outValid_q <= 1'b0;
      result_q   <= '0;
      br_q       <= '0;
      memR_q     <= 1'b0;
      memW_q     <= 1'b0;
      SR_q       <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      acc_q      <= acc_d;
      mulS_q     <= mulS_d;
      outValid_q <= outValid_d;
      result_q   <= result_d;
      br_q       <= br_d;
      memR_q     <= memR_d;
      memW_q     <= memW_d;
      SR_q       <= SR_d;
    end
  end

  assign busy         = (state_q == ST_MUL_RUN);
  assign out_valid    = outValid_q;
  assign ALU_result   = result_q;
  assign Br_addr      = br_q;
  assign mem_r_en_out = outValid_q & memR_q;
  assign mem_w_en_out = outValid_q & memW_q;
  assign SR           = SR_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Scoreboard bench for exe_stage_mc: the driver pushes hand-computed
// expectations as ops are issued, the monitor pops one per out_valid.
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, busy;
  logic [3:0]  EXE_CMD;
  logic        S, imm, MEM_R_EN, MEM_W_EN;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic        out_valid, mem_r_en_out, mem_w_en_out;
  logic [31:0] ALU_result, Br_addr;
  logic [3:0]  SR;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] br;
    logic [3:0]  sr;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   total = 0;
  int   bad   = 0;

  localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010,
                         ADC = 4'b0011, SUB = 4'b0100, SBC = 4'b0101,
                         AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000,
                         MUL = 4'b1010;

  exe_stage_mc #(.DATA_W(32), .IMM_W(24), .MUL_EN(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .busy          (busy),
    .EXE_CMD       (EXE_CMD),
    .S             (S),
    .imm           (imm),
    .MEM_R_EN      (MEM_R_EN),
    .MEM_W_EN      (MEM_W_EN),
    .PC            (PC),
    .Val_Rn        (Val_Rn),
    .Val_Rm        (Val_Rm),
    .Shift_operand (Shift_operand),
    .Signed_imm_24 (Signed_imm_24),
    .out_valid     (out_valid),
    .ALU_result    (ALU_result),
    .Br_addr       (Br_addr),
    .mem_r_en_out  (mem_r_en_out),
    .mem_w_en_out  (mem_w_en_out),
    .SR            (SR)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Hard stop if the bench ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one op on the next falling edge; push its expected output unless dropped
  task automatic applyStimulus(input string tag, input logic [3:0] cmd,
                               input logic s, input logic im,
                               input logic mr, input logic mw,
                               input logic [31:0] pc, input logic [31:0] rn,
                               input logic [31:0] rm, input logic [11:0] so,
                               input logic [23:0] off,
                               input logic [31:0] expRes,
                               input logic [31:0] expBr,
                               input logic [3:0] expSr,
                               input bit expectOut);
    exp_t e;
    @(negedge clk);
    EXE_CMD = cmd; S = s; imm = im; MEM_R_EN = mr; MEM_W_EN = mw;
    PC = pc; Val_Rn = rn; Val_Rm = rm; Shift_operand = so;
    Signed_imm_24 = off; in_valid = 1'b1;
    if (expectOut) begin
      e.tag = tag; e.res = expRes; e.br = expBr; e.sr = expSr;
      e.mr = mr; e.mw = mw;
      expQ.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Count busy cycles while offering an op that must be ignored
  task automatic runMul(input string tag, input int expBusy);
    int busyCnt = 0;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        busyCnt++;
        EXE_CMD = ADD; S = 1'b1; imm = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        Val_Rn = 32'd1; Val_Rm = 32'd1; Shift_operand = 12'h000;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        done = 1;
      end
    end
    checkOutput({tag, ".busyCycles"}, busyCnt, expBusy);
    checkOutput({tag, ".validAfterBusy"}, {31'b0, out_valid}, 32'd1);
  endtask

  // Monitor: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedOut actual=%h required=no_output", ALU_result);
      end else begin
        monExp = expQ.pop_front();
        checkOutput({monExp.tag, ".result"}, ALU_result, monExp.res);
        checkOutput({monExp.tag, ".br"}, Br_addr, monExp.br);
        checkOutput({monExp.tag, ".sr"}, {28'b0, SR}, {28'b0, monExp.sr});
        checkOutput({monExp.tag, ".mem"}, {30'b0, mem_r_en_out, mem_w_en_out},
                    {30'b0, monExp.mr, monExp.mw});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    EXE_CMD = 4'b0; S = 1'b0; imm = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    PC = '0; Val_Rn = '0; Val_Rm = '0; Shift_operand = '0; Signed_imm_24 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset.result", ALU_result, 32'd0);
    checkOutput("reset.br", Br_addr, 32'd0);
    checkOutput("reset.sr", {28'b0, SR}, 32'd0);
    checkOutput("reset.busy", {31'b0, busy}, 32'd0);
    checkOutput("reset.mem", {30'b0, mem_r_en_out, mem_w_en_out}, 32'd0);
    rst = 1'b0;

    // Back-to-back single-cycle ops; each carry-in sees the previous SR
    applyStimulus("add", ADD, 1, 0, 0, 0, 0, 32'd5, 32'd7, 12'h000, 24'h0, 32'd12, 0, 4'b0000, 1);
    applyStimulus("sub", SUB, 1, 0, 0, 0, 0, 32'd0, 32'd1, 12'h000, 24'h0, 32'hFFFFFFFF, 0, 4'b1000, 1);
    applyStimulus("adc0", ADC, 1, 0, 0, 0, 0, 32'd1, 32'd1, 12'h000, 24'h0, 32'd2, 0, 4'b0000, 1);
    applyStimulus("addCarry", ADD, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 12'h000, 24'h0, 32'd0, 0, 4'b0110, 1);
    applyStimulus("adc1", ADC, 1, 0, 0, 0, 0, 32'd1, 32'd1, 12'h000, 24'h0, 32'd3, 0, 4'b0000, 1);
    applyStimulus("addOvf", ADD, 1, 0, 0, 0, 0, 32'h7FFFFFFF, 32'd1, 12'h000, 24'h0, 32'h80000000, 0, 4'b1001, 1);
    applyStimulus("movImm", MOV, 0, 1, 0, 0, 0, 32'd0, 32'd0, 12'h2FF, 24'h0, 32'hF000000F, 0, 4'b1001, 1);
    applyStimulus("movAsr", MOV, 1, 0, 0, 0, 0, 32'd0, 32'h80000000, 12'h240, 24'h0, 32'hF8000000, 0, 4'b1001, 1);
    applyStimulus("movLsr", MOV, 1, 0, 0, 0, 0, 32'd0, 32'h80000000, 12'h220, 24'h0, 32'h08000000, 0, 4'b0001, 1);
    applyStimulus("movRor", MOV, 0, 0, 0, 0, 0, 32'd0, 32'h0000000F, 12'h260, 24'h0, 32'hF0000000, 0, 4'b0001, 1);
    applyStimulus("eor", EOR, 1, 0, 0, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 12'h000, 24'h0, 32'hF0F0F0F0, 0, 4'b1001, 1);
    applyStimulus("and", AND, 1, 0, 0, 0, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 12'h000, 24'h0, 32'd0, 0, 4'b0101, 1);
    applyStimulus("mvn", MVN, 0, 0, 0, 0, 0, 32'd0, 32'd0, 12'h000, 24'h0, 32'hFFFFFFFF, 0, 4'b0101, 1);
    applyStimulus("orr", ORR, 0, 0, 0, 0, 0, 32'h00FF0000, 32'h000000FF, 12'h000, 24'h0, 32'h00FF00FF, 0, 4'b0101, 1);
    applyStimulus("sbcC0", SBC, 1, 0, 0, 0, 0, 32'd10, 32'd3, 12'h000, 24'h0, 32'd6, 0, 4'b0010, 1);
    applyStimulus("sbcC1", SBC, 1, 0, 0, 0, 0, 32'd10, 32'd3, 12'h000, 24'h0, 32'd7, 0, 4'b0010, 1);
    applyStimulus("ldr", ADD, 1, 0, 1, 0, 0, 32'h100, 32'd0, 12'h004, 24'h0, 32'h104, 0, 4'b0010, 1);
    applyStimulus("str", ADD, 0, 0, 0, 1, 0, 32'h200, 32'd0, 12'hFFF, 24'h0, 32'h11FF, 0, 4'b0010, 1);
    applyStimulus("brBack", MOV, 0, 1, 0, 0, 32'd8, 32'd0, 32'd0, 12'h001, 24'hFFFFFF, 32'd1, 32'd4, 4'b0010, 1);
    applyStimulus("brFwd", 4'b0000, 1, 0, 0, 0, 32'h100, 32'd9, 32'd9, 12'h000, 24'h000010, 32'd0, 32'h140, 4'b0010, 1);
    applyStimulus("undef", 4'b1011, 1, 0, 0, 0, 0, 32'd9, 32'd9, 12'h000, 24'h0, 32'd0, 0, 4'b0010, 1);
    idleCycles(2);

    // Multiplies: 32 busy cycles, ops offered meanwhile are ignored
    applyStimulus("mulZero", MUL, 1, 0, 0, 0, 0, 32'h10000, 32'h10000, 12'h000, 24'h0, 32'd0, 0, 4'b0110, 1);
    runMul("mulZero", 32);
    applyStimulus("mulNeg", MUL, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd3, 12'h000, 24'h0, 32'hFFFFFFFD, 0, 4'b1010, 1);
    runMul("mulNeg", 32);
    applyStimulus("mulNoS", MUL, 0, 0, 0, 0, 0, 32'd5, 32'd5, 12'h000, 24'h0, 32'd25, 0, 4'b1010, 1);
    runMul("mulNoS", 32);
    idleCycles(1);

    // Flush mid-multiply: no result, SR untouched
    applyStimulus("mulFlush", MUL, 1, 0, 0, 0, 0, 32'd3, 32'd3, 12'h000, 24'h0, 32'd0, 0, 4'b0000, 0);
    idleCycles(5);
    @(negedge clk);
    flush = 1'b1;
    idleCycles(1);
    checkOutput("mulFlush.busy", {31'b0, busy}, 32'd0);
    checkOutput("mulFlush.outValid", {31'b0, out_valid}, 32'd0);
    idleCycles(40);
    checkOutput("mulFlush.sr", {28'b0, SR}, {28'b0, 4'b1010});

    // Flush together with in_valid drops the incoming op
    applyStimulus("flushDrop", ADD, 1, 0, 0, 0, 0, 32'd0, 32'd0, 12'h000, 24'h0, 32'd0, 0, 4'b0000, 0);
    flush = 1'b1;
    idleCycles(1);
    checkOutput("flushDrop.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("flushDrop.sr", {28'b0, SR}, {28'b0, 4'b1010});

    // Reset mid-multiply returns to idle with everything cleared
    applyStimulus("mulReset", MUL, 1, 0, 0, 0, 0, 32'd5, 32'd5, 12'h000, 24'h0, 32'd0, 0, 4'b0000, 0);
    idleCycles(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mulReset.busy", {31'b0, busy}, 32'd0);
    checkOutput("mulReset.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("mulReset.sr", {28'b0, SR}, 32'd0);
    idleCycles(40);
    applyStimulus("afterReset", ADD, 1, 0, 0, 0, 0, 32'd2, 32'd2, 12'h000, 24'h0, 32'd4, 0, 4'b0000, 1);
    idleCycles(1);

    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
